bp_l15_responder: RTL and testbench



---
 rtl/bp_l15_responder_pkg.sv | 49 ++++
 rtl/bp_l15_responder_mem.sv | 39 +++
 rtl/bp_l15_responder.sv | 172 +++++++++++++++++
 tb/tb_bp_l15_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_l15_responder_pkg.sv
// bp_l15_responder_pkg
//   Shared encodings for the BlackParrot <-> L1.5 responder: request types,
//   return types, access sizes, the FSM state enum, the 128-bit line type
//   and helpers that turn (size, byte offset) into a line byte mask or an
//   alignment check.
package bp_l15_responder_pkg;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] INT_RET  = 4'b0111;

  localparam logic [2:0] SZ_1B  = 3'd0;
  localparam logic [2:0] SZ_2B  = 3'd1;
  localparam logic [2:0] SZ_4B  = 3'd2;
  localparam logic [2:0] SZ_8B  = 3'd3;
  localparam logic [2:0] SZ_16B = 3'd7;

  typedef logic [127:0] line_t;

  typedef enum logic [2:0] {
    e_reset, e_wakeup, e_idle, e_access, e_delay, e_resp
  } state_e;

  // Line byte-enable for a 1/2/4/8-byte store at byte offset off.
  // Anything else (16B, reserved) writes nothing.
  function automatic logic [15:0] byte_mask(input logic [2:0] size, input logic [3:0] off);
    case (size)
      SZ_1B:   byte_mask = 16'h0001 << off;
      SZ_2B:   byte_mask = 16'h0003 << off;
      SZ_4B:   byte_mask = 16'h000f << off;
      SZ_8B:   byte_mask = 16'h00ff << off;
      default: byte_mask = 16'h0000;
    endcase
  endfunction

  // True when off is not a multiple of the access size (1..8 bytes).
  function automatic logic misaligned(input logic [2:0] size, input logic [3:0] off);
    case (size)
      SZ_2B:   misaligned = off[0];
      SZ_4B:   misaligned = |off[1:0];
      SZ_8B:   misaligned = |off[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bp_l15_responder_mem.sv
// bp_l15_responder_mem
//   lines_p x 128-bit backing store, one synchronous read port and one
//   byte-masked write port. Contents are not reset.
//   clk      : clock
//   rd_en    : read strobe, rd_data valid the following cycle
//   rd_idx   : read line index
//   rd_data  : registered read line
//   wr_en    : write strobe
//   wr_idx   : write line index
//   wr_mask  : per-byte write enable (bit b covers line byte b)
//   wr_data  : write line
module bp_l15_responder_mem
  import bp_l15_responder_pkg::*;
#(
  parameter int lines_p = 256,
  parameter int idx_w_p = (lines_p > 1) ? $clog2(lines_p) : 1
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [idx_w_p-1:0] rd_idx,
  output line_t              rd_data,
  input  logic               wr_en,
  input  logic [idx_w_p-1:0] wr_idx,
  input  logic [15:0]        wr_mask,
  input  line_t              wr_data
);

  line_t mem [lines_p];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
    if (wr_en) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_mask[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/bp_l15_responder.sv
// bp_l15_responder
//   L1.5 stand-in that terminates the BP transducer interface. Issues one
//   INT_RET wakeup after reset, then serves LOAD_RQ / STORE_RQ from a local
//   line store, returning LOAD_RET (full 16B line) or ST_ACK.
//   Optional macro BP_L15_RESPONDER_DELAY_EN inserts resp_delay_p idle
//   cycles (e_delay) between the SRAM access and the response.
//   Ports:
//     clk_i, reset_n_i            : clock, async active-low reset
//     transducer_l15_*            : request channel (val held until ack)
//     l15_transducer_ack          : request accepted (only in e_idle)
//     l15_transducer_val/...      : response channel, held until req_ack
//     transducer_l15_req_ack      : response consumed
//     err_o                       : sticky protocol error
module bp_l15_responder
  import bp_l15_responder_pkg::*;
#(
  parameter int lines_p      = 256,
  parameter int resp_delay_p = 0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        transducer_l15_val,
  input  logic [4:0]  transducer_l15_rqtype,
  input  logic        transducer_l15_nc,
  input  logic [2:0]  transducer_l15_size,
  input  logic [39:0] transducer_l15_address,
  input  logic [63:0] transducer_l15_data,
  input  logic [1:0]  transducer_l15_l1rplway,
  output logic        l15_transducer_ack,
  output logic        l15_transducer_val,
  output logic [3:0]  l15_transducer_returntype,
  output logic [63:0] l15_transducer_data_0,
  output logic [63:0] l15_transducer_data_1,
  input  logic        transducer_l15_req_ack,
  output logic        err_o
);

  localparam int IW = (lines_p > 1) ? $clog2(lines_p) : 1;

  state_e        state, state_n;
  logic [4:0]    rq_type_r;
  logic [2:0]    rq_size_r;
  logic [IW+3:0] rq_addr_r;
  logic [63:0]   rq_data_r;
  logic [3:0]    resp_type_r;
  line_t         resp_data_r;
  line_t         rd_data;
  logic          accept, rd_en, wr_en;
  logic          is_load, is_store, store_ok, bad_req;

  // nc and the replacement way have no effect; address bits above the
  // index simply alias.
  logic unused_ok;
  assign unused_ok = ^{transducer_l15_nc, transducer_l15_l1rplway,
                       transducer_l15_address[39:IW+4]};

  assign is_load  = (rq_type_r == LOAD_RQ);
  assign is_store = (rq_type_r == STORE_RQ);
  assign store_ok = is_store && (rq_size_r <= SZ_8B) && !misaligned(rq_size_r, rq_addr_r[3:0]);
  assign bad_req  = (is_store && !store_ok)
                  || (is_load && rq_size_r[2] && (rq_size_r != SZ_16B))
                  || (!is_load && !is_store);

`ifdef BP_L15_RESPONDER_DELAY_EN
  localparam int DW = (resp_delay_p > 1) ? $clog2(resp_delay_p) : 1;
  logic [DW-1:0] dly_cnt;
  logic          dly_done;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            dly_cnt <= '0;
    else if (state == e_delay) dly_cnt <= dly_cnt + 1'b1;
    else                       dly_cnt <= '0;
  end
  assign dly_done = (dly_cnt == DW'(resp_delay_p - 1));
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= e_reset;
    else            state <= state_n;
  end

  always_comb begin
    state_n                   = state;
    accept                    = 1'b0;
    rd_en                     = 1'b0;
    wr_en                     = 1'b0;
    l15_transducer_ack        = 1'b0;
    l15_transducer_val        = 1'b0;
    l15_transducer_returntype = 4'b0000;
    l15_transducer_data_0     = '0;
    l15_transducer_data_1     = '0;
    case (state)
      e_reset: state_n = e_wakeup;
      e_wakeup: begin
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = INT_RET;
        if (transducer_l15_req_ack) state_n = e_idle;
      end
      e_idle: begin
        l15_transducer_ack = transducer_l15_val;
        if (transducer_l15_val) begin
          accept  = 1'b1;
          // Unknown request types never touch the SRAM.
          rd_en   = (transducer_l15_rqtype == LOAD_RQ) || (transducer_l15_rqtype == STORE_RQ);
          state_n = e_access;
        end
      end
      e_access: begin
        wr_en = store_ok;
`ifdef BP_L15_RESPONDER_DELAY_EN
        state_n = (resp_delay_p == 0) ? e_resp : e_delay;
`else
        state_n = e_resp;
`endif
      end
      e_delay: begin
`ifdef BP_L15_RESPONDER_DELAY_EN
        if (dly_done) state_n = e_resp;
`else
        state_n = e_resp;
`endif
      end
      e_resp: begin
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = resp_type_r;
        l15_transducer_data_0     = resp_data_r[63:0];
        l15_transducer_data_1     = resp_data_r[127:64];
        if (transducer_l15_req_ack) state_n = e_idle;
      end
      default: state_n = e_reset;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rq_type_r   <= '0;
      rq_size_r   <= '0;
      rq_addr_r   <= '0;
      rq_data_r   <= '0;
      resp_type_r <= '0;
      resp_data_r <= '0;
      err_o       <= 1'b0;
    end else begin
      if (accept) begin
        rq_type_r <= transducer_l15_rqtype;
        rq_size_r <= transducer_l15_size;
        rq_addr_r <= transducer_l15_address[IW+3:0];
        rq_data_r <= transducer_l15_data;
      end
      if (state == e_access) begin
        resp_type_r <= is_load ? LOAD_RET : ST_ACK;
        resp_data_r <= is_load ? rd_data : '0;
        if (bad_req) err_o <= 1'b1;
      end
      if (transducer_l15_req_ack && !l15_transducer_val) err_o <= 1'b1;
    end
  end

  // Store data is already replicated per size, so line byte b takes data
  // lane b[2:0]; the mask picks the destination bytes.
  bp_l15_responder_mem #(.lines_p(lines_p), .idx_w_p(IW)) u_mem (
    .clk     (clk_i),
    .rd_en   (rd_en),
    .rd_idx  (transducer_l15_address[4 +: IW]),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (rq_addr_r[4 +: IW]),
    .wr_mask (byte_mask(rq_size_r, rq_addr_r[3:0])),
    .wr_data ({2{rq_data_r}})
  );

endmodule

// File: tb/tb_bp_l15_responder.sv
// tb_bp_l15_responder
//   Directed stimulus with a response scoreboard: each request pushes its
//   hand-computed response; a negedge monitor pops and compares on every
//   val && req_ack handshake.
module tb_bp_l15_responder;

  localparam int DLY = 4;
`ifdef BP_L15_RESPONDER_DELAY_EN
  localparam int LAT = 2 + DLY;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        val_in = 1'b0;
  logic [4:0]  rqtype = '0;
  logic        nc = 1'b0;
  logic [2:0]  size = '0;
  logic [39:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  rplway = '0;
  logic        ack, val, err;
  logic [3:0]  rtype;
  logic [63:0] d0, d1;
  logic        req_ack = 1'b0;

  typedef struct packed {
    logic [3:0]  rt;
    logic [63:0] d1;
    logic [63:0] d0;
  } resp_t;

  resp_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    acc;

  bp_l15_responder #(.lines_p(256), .resp_delay_p(DLY)) dut (
    .clk_i                     (clk),
    .reset_n_i                 (rst_n),
    .transducer_l15_val        (val_in),
    .transducer_l15_rqtype     (rqtype),
    .transducer_l15_nc         (nc),
    .transducer_l15_size       (size),
    .transducer_l15_address    (addr),
    .transducer_l15_data       (wdata),
    .transducer_l15_l1rplway   (rplway),
    .l15_transducer_ack        (ack),
    .l15_transducer_val        (val),
    .l15_transducer_returntype (rtype),
    .l15_transducer_data_0     (d0),
    .l15_transducer_data_1     (d1),
    .transducer_l15_req_ack    (req_ack),
    .err_o                     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [131:0] got, input logic [131:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && val && req_ack) begin
      if (q.size() == 0) chk("unexpected response", {rtype, d1, d0}, '0);
      else chk("response", {rtype, d1, d0}, q.pop_front());
    end
  end

  task automatic send(input logic [4:0] t, input logic [2:0] s, input logic [39:0] a,
                      input logic [63:0] d, input logic [3:0] ert,
                      input logic [63:0] e0, input logic [63:0] e1, output int acc_cyc);
    int n;
    @(posedge clk); #1;
    rqtype = t; size = s; addr = a; wdata = d; val_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ack && n < 30) begin @(negedge clk); n++; end
    if (!ack) chk("ack timeout", 132'(0), 132'(1));
    acc_cyc = cyc;
    q.push_back('{rt: ert, d1: e1, d0: e0});
    @(posedge clk); #1;
    val_in = 1'b0;
  endtask

  // Wait for val, hold req_ack low for hold cycles checking stability, then consume.
  task automatic wait_resp(input int hold, input int lat, input int acc_cyc);
    int n;
    logic [131:0] snap;
    n = 0;
    @(negedge clk);
    while (!val && n < 40) begin @(negedge clk); n++; end
    if (!val) chk("val timeout", 132'(0), 132'(1));
    if (lat >= 0) chk("latency", 132'(cyc - acc_cyc), 132'(lat));
    snap = {rtype, d1, d0};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held val", 132'(val), 132'(1));
      chk("held outputs", {rtype, d1, d0}, snap);
      chk("no ack while busy", 132'(ack), 132'(0));
    end
    @(posedge clk); #1; req_ack = 1'b1;
    @(posedge clk); #1; req_ack = 1'b0;
    @(negedge clk);
    chk("val drops after req_ack", 132'(val), 132'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and boot wakeup
    repeat (2) @(negedge clk);
    chk("reset val", 132'(val), 132'(0));
    chk("reset ack", 132'(ack), 132'(0));
    chk("reset outputs", {rtype, d1, d0}, '0);
    chk("reset err", 132'(err), 132'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    q.push_back('{rt: 4'b0111, d1: '0, d0: '0});
    wait_resp(5, -1, 0);

    // Zero line 8 upper half, then 8B store / 16B load
    send(5'b00001, 3'd3, 40'h88, 64'h0, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00001, 3'd3, 40'h80, 64'h1122334455667788, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00000, 3'd7, 40'h80, 64'h0, 4'b0000, 64'h1122334455667788, 64'h0, acc); wait_resp(0, LAT, acc);

    // 1B store at byte 13
    send(5'b00001, 3'd0, 40'h8D, {8{8'hAB}}, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00000, 3'd7, 40'h80, 64'h0, 4'b0000, 64'h1122334455667788, 64'h0000AB0000000000, acc);
    wait_resp(0, LAT, acc);

    // Misaligned 4B store: ST_ACK, no write, sticky err
    chk("err before misaligned", 132'(err), 132'(0));
    send(5'b00001, 3'd2, 40'h82, 64'hDEADBEEFDEADBEEF, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    chk("err after misaligned", 132'(err), 132'(1));
    send(5'b00000, 3'd7, 40'h80, 64'h0, 4'b0000, 64'h1122334455667788, 64'h0000AB0000000000, acc);
    wait_resp(0, LAT, acc);
    chk("err sticky", 132'(err), 132'(1));

    // Line 9: zero, 2B and 4B merges, 16B store ignored, byte-size load returns line
    send(5'b00001, 3'd3, 40'h90, 64'h0, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00001, 3'd3, 40'h98, 64'h0, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00001, 3'd1, 40'h96, {4{16'h1234}}, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00001, 3'd2, 40'h9C, {2{32'hCAFEF00D}}, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00001, 3'd7, 40'h90, {64{1'b1}}, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);
    send(5'b00000, 3'd0, 40'h9F, 64'h0, 4'b0000, 64'h1234000000000000, 64'hCAFEF00D00000000, acc);
    wait_resp(0, LAT, acc);

    // Aliasing above the index and an unknown rqtype
    send(5'b00000, 3'd3, 40'h1080, 64'h0, 4'b0000, 64'h1122334455667788, 64'h0000AB0000000000, acc);
    wait_resp(0, LAT, acc);
    send(5'b00010, 3'd3, 40'h80, 64'h0, 4'b0100, 64'h0, 64'h0, acc); wait_resp(0, LAT, acc);

    // Back-to-back: second request held while first response is stalled
    send(5'b00000, 3'd7, 40'h80, 64'h0, 4'b0000, 64'h1122334455667788, 64'h0000AB0000000000, acc);
    rqtype = 5'b00000; size = 3'd7; addr = 40'h90; val_in = 1'b1;
    wait_resp(3, LAT, acc);
    chk("ack right after req_ack", 132'(ack), 132'(1));
    acc = cyc;
    q.push_back('{rt: 4'b0000, d1: 64'hCAFEF00D00000000, d0: 64'h1234000000000000});
    @(posedge clk); #1; val_in = 1'b0;
    wait_resp(0, LAT, acc);

    // Reset mid-transaction: outputs clear at once, wakeup repeats
    send(5'b00000, 3'd7, 40'h80, 64'h0, 4'b0000, 64'h1122334455667788, 64'h0000AB0000000000, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid reset val", 132'(val), 132'(0));
    chk("mid reset outputs", {rtype, d1, d0}, '0);
    chk("mid reset err", 132'(err), 132'(0));
    q.delete();
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    q.push_back('{rt: 4'b0111, d1: '0, d0: '0});
    wait_resp(1, -1, 0);

    // Stray req_ack in idle
    @(posedge clk); #1; req_ack = 1'b1;
    @(posedge clk); #1; req_ack = 1'b0;
    @(negedge clk);
    chk("err on stray req_ack", 132'(err), 132'(1));

    // Store contents survive reset
    send(5'b00000, 3'd7, 40'h80, 64'h0, 4'b0000, 64'h1122334455667788, 64'h0000AB0000000000, acc);
    wait_resp(0, LAT, acc);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 132'(q.size()), 132'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
